// File: rtl/conv_pkg.sv
// Shared types and elaboration-time helpers for the conv row path.
package conv_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 8;
   localparam int unsigned DEF_IW         = 7;

   // One lane word: IW pixels of DATA_WIDTH bits.
   typedef logic [DEF_IW-1:0][DEF_DATA_WIDTH-1:0] lane_word_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PAD_T,
      ST_DATA,
      ST_PAD_B,
      ST_NEXT,
      ST_DRAIN
   } feeder_state_e;

   // Ceiling division.
   function automatic int unsigned ceil(input int unsigned num, input int unsigned den);
      return (num + den - 1) / den;
   endfunction

   // Bits needed to hold v distinct values; never less than 1.
   function automatic int unsigned log2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/row_feeder_addr_gen.sv
// Word/row/batch counters and the RAM word-address register for the row feeder.
module row_feeder_addr_gen
   import conv_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH    = 32,
   parameter int unsigned BATCH_WIDTH   = 8,
   parameter int unsigned WORDS_PER_ROW = 512,
   parameter int unsigned ROW_CW        = 5
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   i_load,        // start accepted: capture base, clear counters
   input  logic [ADDR_WIDTH-1:0]  i_base,
   input  logic                   i_advance,     // one word issued in the current phase
   input  logic                   i_addr_inc,    // that word was a RAM read
   input  logic [ROW_CW-1:0]      i_row_term,    // last row index of the current phase
   input  logic                   i_batch_adv,
   input  logic [BATCH_WIDTH-1:0] i_batch_term,
   input  logic                   i_rewind,      // loop mode: address back to base
   output logic [ADDR_WIDTH-1:0]  o_addr,
   output logic                   o_phase_last,
   output logic                   o_batch_last
);

   localparam int unsigned        WORD_CW   = log2(WORDS_PER_ROW);
   localparam logic [WORD_CW-1:0] WORD_TERM = WORD_CW'(WORDS_PER_ROW - 1);

   logic [WORD_CW-1:0]     r_word;
   logic [ROW_CW-1:0]      r_row;
   logic [BATCH_WIDTH-1:0] r_batch;
   logic [ADDR_WIDTH-1:0]  r_addr;
   logic [ADDR_WIDTH-1:0]  r_base;
   logic                   w_word_last;
   logic                   w_row_last;

   assign w_word_last  = (r_word == WORD_TERM);
   assign w_row_last   = (r_row == i_row_term);
   assign o_phase_last = w_word_last & w_row_last;
   assign o_batch_last = (r_batch == i_batch_term);
   assign o_addr       = r_addr;

   // Word counter wraps into the row counter; the row counter wraps at the end of a phase.
   always_ff @(posedge clk) begin
      if (!rstn || i_load) begin
         r_word <= '0;
         r_row  <= '0;
      end else if (i_advance) begin
         if (w_word_last) begin
            r_word <= '0;
            r_row  <= w_row_last ? '0 : r_row + 1'b1;
         end else begin
            r_word <= r_word + 1'b1;
         end
      end
   end

   // Batch counter, stepped once per pass through NEXT.
   always_ff @(posedge clk) begin
      if (!rstn || i_load) begin
         r_batch <= '0;
      end else if (i_batch_adv) begin
         r_batch <= o_batch_last ? '0 : r_batch + 1'b1;
      end
   end

   // Address register: contiguous across rows and batches, rewound only in loop mode.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_base <= '0;
         r_addr <= '0;
      end else if (i_load) begin
         r_base <= i_base;
         r_addr <= i_base;
      end else if (i_rewind) begin
         r_addr <= r_base;
      end else if (i_addr_inc) begin
         r_addr <= r_addr + 1'b1;
      end
   end

endmodule

// File: rtl/row_feeder_ctrl.sv
// Multi-lane row producer: streams padded feature-map rows from a 1-cycle RAM into LANES FIFOs.
module row_feeder_ctrl
   import conv_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned LANES         = 2,
   parameter int unsigned IW            = 7,
   parameter int unsigned ROWS          = 25,
   parameter int unsigned WORDS_PER_ROW = 512,
   parameter int unsigned PAD_TOP       = 1,
   parameter int unsigned PAD_BOT       = 1,
   parameter int unsigned ADDR_WIDTH    = 32,
   parameter int unsigned BATCH_WIDTH   = 8
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic                           start,
   input  logic                           abort,
   input  logic [ADDR_WIDTH-1:0]          cfg_base,
   input  logic [BATCH_WIDTH-1:0]         cfg_batches,
   output logic                           mem_rd_en,
   output logic [ADDR_WIDTH-1:0]          mem_addr,
   input  logic [LANES*IW*DATA_WIDTH-1:0] mem_rd_data,
   input  logic [LANES-1:0]               fifo_full,
   output logic [LANES-1:0]               fifo_wren,
   output logic [LANES*IW*DATA_WIDTH-1:0] fifo_din,
   output logic                           busy,
   output logic                           done
);

   localparam int unsigned       ROW_CW    = log2(max3(PAD_TOP, ROWS, PAD_BOT) + 1);
   localparam logic [ROW_CW-1:0] TOP_TERM  = ROW_CW'((PAD_TOP > 0) ? PAD_TOP - 1 : 0);
   localparam logic [ROW_CW-1:0] DATA_TERM = ROW_CW'((ROWS > 0) ? ROWS - 1 : 0);
   localparam logic [ROW_CW-1:0] BOT_TERM  = ROW_CW'((PAD_BOT > 0) ? PAD_BOT - 1 : 0);

   feeder_state_e          r_state;
   feeder_state_e          w_next;
   logic                   r_ret_vld;
   logic [BATCH_WIDTH-1:0] r_batches;

   logic                   w_ok;
   logic                   w_loop;
   logic                   w_issue_pad;
   logic                   w_issue_rd;
   logic                   w_load;
   logic                   w_rewind;
   logic                   w_batch_adv;
   logic                   w_done;
   logic [ROW_CW-1:0]      w_row_term;
   logic [BATCH_WIDTH-1:0] w_batch_term;
   logic                   w_phase_last;
   logic                   w_batch_last;
   logic [ADDR_WIDTH-1:0]  w_addr;

   assign w_ok         = ~(|fifo_full);
   assign w_loop       = (r_batches == '0);
   assign w_batch_term = r_batches - 1'b1;

   row_feeder_addr_gen #(
      .ADDR_WIDTH    (ADDR_WIDTH),
      .BATCH_WIDTH   (BATCH_WIDTH),
      .WORDS_PER_ROW (WORDS_PER_ROW),
      .ROW_CW        (ROW_CW)
   ) u_addr_gen (
      .clk          (clk),
      .rstn         (rstn),
      .i_load       (w_load),
      .i_base       (cfg_base),
      .i_advance    (w_issue_pad | w_issue_rd),
      .i_addr_inc   (w_issue_rd),
      .i_row_term   (w_row_term),
      .i_batch_adv  (w_batch_adv),
      .i_batch_term (w_batch_term),
      .i_rewind     (w_rewind),
      .o_addr       (w_addr),
      .o_phase_last (w_phase_last),
      .o_batch_last (w_batch_last)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rstn) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   // Read-return pipeline and batch-count capture; abort drops the in-flight return.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_ret_vld <= 1'b0;
         r_batches <= '0;
      end else begin
         r_ret_vld <= w_issue_rd & ~abort;
         if (w_load) r_batches <= cfg_batches;
      end
   end

   // Next-state and issue decode. Pad words wait one cycle behind a pending read return
   // so at most one FIFO write happens per cycle and word order is kept.
   always_comb begin
      w_next      = r_state;
      w_issue_pad = 1'b0;
      w_issue_rd  = 1'b0;
      w_load      = 1'b0;
      w_rewind    = 1'b0;
      w_batch_adv = 1'b0;
      w_done      = 1'b0;
      w_row_term  = '0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_load = 1'b1;
               if (PAD_TOP > 0) w_next = ST_PAD_T;
               else             w_next = ST_DATA;
            end
         end
         ST_PAD_T: begin
            w_row_term = TOP_TERM;
            if (w_ok && !r_ret_vld) begin
               w_issue_pad = 1'b1;
               if (w_phase_last) w_next = ST_DATA;
            end
         end
         ST_DATA: begin
            w_row_term = DATA_TERM;
            if (w_ok) begin
               w_issue_rd = 1'b1;
               if (w_phase_last) begin
                  if (PAD_BOT > 0) w_next = ST_PAD_B;
                  else             w_next = ST_NEXT;
               end
            end
         end
         ST_PAD_B: begin
            w_row_term = BOT_TERM;
            if (w_ok && !r_ret_vld) begin
               w_issue_pad = 1'b1;
               if (w_phase_last) w_next = ST_NEXT;
            end
         end
         ST_NEXT: begin
            w_batch_adv = 1'b1;
            if (w_loop || !w_batch_last) begin
               w_rewind = w_loop;
               if (PAD_TOP > 0) w_next = ST_PAD_T;
               else             w_next = ST_DATA;
            end else begin
               w_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!r_ret_vld) begin
               w_done = 1'b1;
               w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
      if (abort) begin
         w_next = ST_IDLE;
         w_load = 1'b0;
         w_done = 1'b0;
      end
   end

   assign mem_rd_en = w_issue_rd;
   assign mem_addr  = w_issue_rd ? w_addr : '0;
   assign fifo_wren = {LANES{w_issue_pad | r_ret_vld}};
   assign fifo_din  = r_ret_vld ? mem_rd_data : '0;
   assign busy      = (r_state != ST_IDLE);
   assign done      = w_done;

endmodule

// File: tb/tb_row_feeder_ctrl.sv
// Directed bench for row_feeder_ctrl: ROWS=3, WORDS_PER_ROW=4, padded and unpadded instances.
module tb_row_feeder_ctrl;

   localparam int LW = 2 * 7 * 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rstn, start, abort;
   logic [31:0]   cfg_base;
   logic [7:0]    cfg_batches;
   logic          mem_rd_en, busy, done;
   logic [31:0]   mem_addr;
   logic [LW-1:0] mem_rd_data, fifo_din;
   logic [1:0]    fifo_full, fifo_wren;

   logic          start_z;
   logic [31:0]   cfg_base_z;
   logic [7:0]    cfg_batches_z;
   logic          mem_rd_en_z, busy_z, done_z;
   logic [31:0]   mem_addr_z;
   logic [LW-1:0] mem_rd_data_z, fifo_din_z;
   logic [1:0]    fifo_wren_z;
   logic          abort_z = 1'b0;
   logic [1:0]    fifo_full_z = 2'b00;

   row_feeder_ctrl #(
      .DATA_WIDTH(8), .LANES(2), .IW(7), .ROWS(3), .WORDS_PER_ROW(4),
      .PAD_TOP(1), .PAD_BOT(1), .ADDR_WIDTH(32), .BATCH_WIDTH(8)
   ) u_dut (
      .clk(clk), .rstn(rstn), .start(start), .abort(abort),
      .cfg_base(cfg_base), .cfg_batches(cfg_batches),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
      .fifo_full(fifo_full), .fifo_wren(fifo_wren), .fifo_din(fifo_din),
      .busy(busy), .done(done)
   );

   row_feeder_ctrl #(
      .DATA_WIDTH(8), .LANES(2), .IW(7), .ROWS(3), .WORDS_PER_ROW(4),
      .PAD_TOP(0), .PAD_BOT(0), .ADDR_WIDTH(32), .BATCH_WIDTH(8)
   ) u_dut_z (
      .clk(clk), .rstn(rstn), .start(start_z), .abort(abort_z),
      .cfg_base(cfg_base_z), .cfg_batches(cfg_batches_z),
      .mem_rd_en(mem_rd_en_z), .mem_addr(mem_addr_z), .mem_rd_data(mem_rd_data_z),
      .fifo_full(fifo_full_z), .fifo_wren(fifo_wren_z), .fifo_din(fifo_din_z),
      .busy(busy_z), .done(done_z)
   );

   // RAM content: each lane carries a tag byte, a marker and the word address.
   function automatic logic [LW-1:0] mk(input logic [31:0] a);
      return {8'h02, 16'hC0DE, a, 8'h01, 16'hC0DE, a};
   endfunction

   always @(posedge clk) if (mem_rd_en)   mem_rd_data   <= mk(mem_addr);
   always @(posedge clk) if (mem_rd_en_z) mem_rd_data_z <= mk(mem_addr_z);

   int unsigned   n_chk = 0, n_pass = 0;
   int unsigned   cyc = 0, wr_cnt = 0, done_cnt = 0, rd_full = 0, wren_bad = 0;
   int unsigned   last_wr = 0, done_at = 0, done_cnt_z = 0;
   logic [LW-1:0] got_q[$], got_z[$], exp_q[$];
   logic [31:0]   addr_q[$];

   // Write/read/done monitor, sampled on the falling edge.
   always @(negedge clk) begin
      cyc++;
      if (|fifo_wren) begin
         got_q.push_back(fifo_din);
         wr_cnt++;
         last_wr = cyc;
         if (fifo_wren != 2'b11) wren_bad++;
      end
      if (mem_rd_en) begin
         addr_q.push_back(mem_addr);
         if (|fifo_full) rd_full++;
      end
      if (done) begin
         done_cnt++;
         done_at = cyc;
      end
      if (|fifo_wren_z) got_z.push_back(fifo_din_z);
      if (done_z) done_cnt_z++;
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Expected word stream: pad zeros, 12 data words, pad zeros per batch.
   task automatic build(input logic [31:0] base, input int nb, input bit loop,
                        input int pt, input int pb);
      logic [31:0] a;
      exp_q.delete();
      a = base;
      for (int b = 0; b < nb; b++) begin
         if (loop) a = base;
         repeat (pt * 4) exp_q.push_back('0);
         for (int i = 0; i < 12; i++) begin
            exp_q.push_back(mk(a));
            a++;
         end
         repeat (pb * 4) exp_q.push_back('0);
      end
   endtask

   task automatic cmp_stream(input string tag, input int s, input int n);
      for (int i = 0; i < n; i++) check(tag, got_q[s + i], exp_q[i]);
   endtask

   task automatic go(input logic [31:0] base, input logic [7:0] nb);
      cfg_base    = base;
      cfg_batches = nb;
      start       = 1'b1;
      tick();
      start       = 1'b0;
      cfg_base    = 32'hDEAD_0000;
      cfg_batches = 8'd7;
   endtask

   task automatic wait_idle(input string tag);
      int k;
      k = 0;
      while (busy && k < 500) begin
         tick();
         k++;
      end
      check({tag, "_idle"}, busy, 1'b0);
      tick(2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int s, sa, w0, rf0, d0, k, n;
      rstn = 1'b0; start = 1'b0; abort = 1'b0; fifo_full = 2'b00;
      cfg_base = '0; cfg_batches = '0;
      start_z = 1'b0; cfg_base_z = '0; cfg_batches_z = '0;
      tick(3);
      check("rst_busy", busy, 1'b0);
      check("rst_rd_en", mem_rd_en, 1'b0);
      check("rst_wren", fifo_wren, 2'b00);
      check("rst_done", done, 1'b0);
      check("rst_addr", mem_addr, 32'h0);
      check("rst_din", fifo_din, '0);
      rstn = 1'b1;
      tick();

      // 1: single batch, FIFOs never full
      s = got_q.size(); sa = addr_q.size(); d0 = done_cnt;
      build(32'h100, 1, 1'b0, 1, 1);
      go(32'h100, 8'd1);
      wait_idle("s1");
      check("s1_count", got_q.size() - s, 20);
      cmp_stream("s1_word", s, 20);
      check("s1_first_addr", addr_q[sa], 32'h100);
      check("s1_done_cnt", done_cnt - d0, 1);
      check("s1_done_after_last_wr", (done_at > last_wr) && (done_at - last_wr <= 2), 1'b1);
      check("s1_wren_lanes", wren_bad, 0);

      // 2: lane 1 full for 5 cycles mid-DATA
      s = got_q.size(); sa = addr_q.size(); rf0 = rd_full; d0 = done_cnt;
      build(32'h100, 1, 1'b0, 1, 1);
      go(32'h100, 8'd1);
      k = 0;
      while (addr_q.size() - sa < 3 && k < 100) begin
         tick();
         k++;
      end
      w0 = wr_cnt;
      fifo_full = 2'b10;
      tick(5);
      check("s2_wr_while_full", (wr_cnt - w0) <= 1, 1'b1);
      fifo_full = 2'b00;
      wait_idle("s2");
      check("s2_rd_while_full", rd_full - rf0, 0);
      check("s2_count", got_q.size() - s, 20);
      cmp_stream("s2_word", s, 20);
      check("s2_done_cnt", done_cnt - d0, 1);

      // 3: three batches, contiguous addressing
      s = got_q.size(); sa = addr_q.size(); d0 = done_cnt;
      build(32'h100, 3, 1'b0, 1, 1);
      go(32'h100, 8'd3);
      wait_idle("s3");
      check("s3_count", got_q.size() - s, 60);
      cmp_stream("s3_word", s, 60);
      check("s3_batch2_addr", addr_q[sa + 24], 32'h118);
      check("s3_done_cnt", done_cnt - d0, 1);

      // 4: loop mode, abort after 50 writes
      s = got_q.size(); sa = addr_q.size(); d0 = done_cnt;
      build(32'h100, 3, 1'b1, 1, 1);
      go(32'h100, 8'd0);
      k = 0;
      while (wr_cnt - s < 50 && k < 300) begin
         tick();
         k++;
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("s4_busy_after_abort", busy, 1'b0);
      w0 = wr_cnt;
      tick(5);
      check("s4_no_wr_after_abort", wr_cnt - w0, 0);
      n = got_q.size() - s;
      check("s4_count", (n >= 50) && (n <= 51), 1'b1);
      cmp_stream("s4_word", s, n);
      check("s4_wrap_b1", addr_q[sa + 12], 32'h100);
      check("s4_wrap_b2", addr_q[sa + 24], 32'h100);
      check("s4_no_done", done_cnt - d0, 0);
      cfg_base = 32'h100; cfg_batches = 8'd1;
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      tick();
      check("s4_start_with_abort", busy, 1'b0);
      s = got_q.size();
      go(32'h100, 8'd1);
      check("s4_restart_busy", busy, 1'b1);
      wait_idle("s4r");
      check("s4_restart_count", got_q.size() - s, 20);

      // 6: one-cycle reset mid-DATA
      sa = addr_q.size(); d0 = done_cnt;
      go(32'h100, 8'd1);
      k = 0;
      while (addr_q.size() - sa < 4 && k < 100) begin
         tick();
         k++;
      end
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      check("s6_busy", busy, 1'b0);
      check("s6_rd_en", mem_rd_en, 1'b0);
      check("s6_wren", fifo_wren, 2'b00);
      w0 = wr_cnt;
      tick(3);
      check("s6_no_inflight_wr", wr_cnt - w0, 0);
      check("s6_no_done", done_cnt - d0, 0);

      // 5: unpadded instance, DATA immediately after start
      s = got_z.size();
      cfg_base_z = 32'h200; cfg_batches_z = 8'd1;
      start_z = 1'b1;
      tick();
      start_z = 1'b0;
      check("s5_first_rd", mem_rd_en_z, 1'b1);
      check("s5_first_addr", mem_addr_z, 32'h200);
      k = 0;
      while (busy_z && k < 200) begin
         tick();
         k++;
      end
      check("s5_idle", busy_z, 1'b0);
      tick(2);
      check("s5_count", got_z.size() - s, 12);
      for (int i = 0; i < 12; i++) check("s5_word", got_z[s + i], mk(32'h200 + i));
      check("s5_done_cnt", done_cnt_z, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
